// File: rtl/mult_accum_pkg.sv
// Shared types and default widths for the multiplier-product accumulation stage.
// Optional build macro used by this slice: ACC_SATURATE_EN (saturating accumulator).
package mult_accum_pkg;

  // Frame FSM: ACC collects products, OUT holds the finished frame sum.
  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  // Product width matches the 11x11 unsigned multiplier output.
  localparam int PROD_WIDTH_DEF = 22;
  // Accumulator and result width; must be at least PROD_WIDTH.
  localparam int ACC_WIDTH_DEF  = 32;
  // Width of the programmable frame length.
  localparam int LEN_WIDTH_DEF  = 8;

endpackage : mult_accum_pkg

// File: rtl/mult_accum_stage_acc_add.sv
// acc_add: combinational accumulator adder for mult_accum_stage.
// Adds a zero-extended product to the running sum and reports the carry-out.
// Build macro ACC_SATURATE_EN: when defined the sum clamps to all-ones on carry-out;
// otherwise the sum wraps modulo 2^ACC_WIDTH.
module acc_add
  import mult_accum_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0]  i_acc,
  input  logic [PROD_WIDTH-1:0] i_prod,
  output logic [ACC_WIDTH-1:0]  o_sum,
  output logic                  o_carry
);

  logic [ACC_WIDTH:0] w_accExt;
  logic [ACC_WIDTH:0] w_prodExt;
  logic [ACC_WIDTH:0] w_full;

  // One extra bit on both operands so the carry-out falls out of the addition.
  assign w_accExt  = {1'b0, i_acc};
  assign w_prodExt = (ACC_WIDTH + 1)'(i_prod);
  assign w_full    = w_accExt + w_prodExt;
  assign o_carry   = w_full[ACC_WIDTH];

`ifdef ACC_SATURATE_EN
  // Clamp to the largest representable value on carry-out. Once clamped, any
  // further non-zero product carries out again, so the sum stays pinned.
  assign o_sum = w_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];
`else
  // Plain modulo-2^ACC_WIDTH wrap; the carry is only reported, never applied.
  assign o_sum = w_full[ACC_WIDTH-1:0];
`endif

endmodule : acc_add

// File: rtl/mult_accum_stage.sv
// mult_accum_stage: sums a programmable-length frame of multiplier products
// and presents the frame sum (plus an overflow flag) on a held valid/ready port.
// Build macro ACC_SATURATE_EN selects a saturating accumulator (see acc_add).
module mult_accum_stage
  import mult_accum_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic                  out_ovf
);

  state_t                r_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [LEN_WIDTH-1:0]  r_lenQ;
  logic                  r_ovf;
  logic [ACC_WIDTH-1:0]  r_outSum;
  logic                  r_outOvf;

  logic                  w_inFire;
  logic                  w_outFire;
  logic                  w_firstOfFrame;
  logic [LEN_WIDTH-1:0]  w_lenNew;
  logic [LEN_WIDTH-1:0]  w_lenEff;
  logic [LEN_WIDTH:0]    w_countInc;
  logic                  w_frameDone;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_carry;

  // Both handshake sides are decoded from state only, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == OUT);
  assign out_sum   = r_outSum;
  assign out_ovf   = r_outOvf;

  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = out_valid && out_ready;

  // The first product of a frame uses the live frame_len (0 means 1); later
  // products use the length captured with that first product.
  assign w_firstOfFrame = (r_count == '0);
  assign w_lenNew       = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
  assign w_lenEff       = w_firstOfFrame ? w_lenNew : r_lenQ;
  assign w_countInc     = {1'b0, r_count} + (LEN_WIDTH + 1)'(1);
  assign w_frameDone    = (w_countInc == {1'b0, w_lenEff});

  acc_add #(
    .PROD_WIDTH (PROD_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_accAdd (
    .i_acc   (r_acc),
    .i_prod  (in_prod),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Frame FSM with accumulator, product counter, length latch and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ACC;
      r_acc    <= '0;
      r_count  <= '0;
      r_lenQ   <= LEN_WIDTH'(1);
      r_ovf    <= 1'b0;
      r_outSum <= '0;
      r_outOvf <= 1'b0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_inFire) begin
            if (w_firstOfFrame) begin
              r_lenQ <= w_lenNew;
            end
            if (w_frameDone) begin
              r_outSum <= w_sum;
              r_outOvf <= r_ovf | w_carry;
              r_acc    <= '0;
              r_count  <= '0;
              r_ovf    <= 1'b0;
              r_state  <= OUT;
            end else begin
              r_acc   <= w_sum;
              r_count <= w_countInc[LEN_WIDTH-1:0];
              r_ovf   <= r_ovf | w_carry;
            end
          end
        end
        OUT: begin
          if (w_outFire) begin
            r_state <= ACC;
          end
        end
        default: begin
          r_state <= ACC;
        end
      endcase
    end
  end

endmodule : mult_accum_stage

// File: tb/tb_mult_accum_stage.sv
// tb_mult_accum_stage: directed bench for mult_accum_stage.
// dutA uses default widths; dutB uses ACC_WIDTH = 23 to reach overflow.
// Expected overflow-frame sum depends on build macro ACC_SATURATE_EN.
module tb_mult_accum_stage;

  logic        clk;
  logic        rst;

  logic [7:0]  aFrameLen;
  logic        aInValid;
  logic        aInReady;
  logic [21:0] aInProd;
  logic        aOutValid;
  logic        aOutReady;
  logic [31:0] aOutSum;
  logic        aOutOvf;

  logic [7:0]  bFrameLen;
  logic        bInValid;
  logic        bInReady;
  logic [21:0] bInProd;
  logic        bOutValid;
  logic        bOutReady;
  logic [22:0] bOutSum;
  logic        bOutOvf;

  int testsRun  = 0;
  int failCount = 0;

  mult_accum_stage dutA (
    .clk       (clk),
    .rst       (rst),
    .frame_len (aFrameLen),
    .in_valid  (aInValid),
    .in_ready  (aInReady),
    .in_prod   (aInProd),
    .out_valid (aOutValid),
    .out_ready (aOutReady),
    .out_sum   (aOutSum),
    .out_ovf   (aOutOvf)
  );

  mult_accum_stage #(
    .PROD_WIDTH (22),
    .ACC_WIDTH  (23),
    .LEN_WIDTH  (8)
  ) dutB (
    .clk       (clk),
    .rst       (rst),
    .frame_len (bFrameLen),
    .in_valid  (bInValid),
    .in_ready  (bInReady),
    .in_prod   (bInProd),
    .out_valid (bOutValid),
    .out_ready (bOutReady),
    .out_sum   (bOutSum),
    .out_ovf   (bOutOvf)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product to dutA for a single edge (dutA is in ACC at that edge).
  task automatic applyStimulus(input logic [21:0] prod);
    aInValid = 1'b1;
    aInProd  = prod;
    tick();
    aInValid = 1'b0;
  endtask

  // Present one product to dutB for a single edge.
  task automatic applyStimulusB(input logic [21:0] prod);
    bInValid = 1'b1;
    bInProd  = prod;
    tick();
    bInValid = 1'b0;
  endtask

  // Linear directed sequence.
  initial begin
    rst       = 1'b1;
    aFrameLen = 8'd4;
    aInValid  = 1'b0;
    aInProd   = '0;
    aOutReady = 1'b1;
    bFrameLen = 8'd3;
    bInValid  = 1'b0;
    bInProd   = '0;
    bOutReady = 1'b1;

    tick();
    tick();
    checkOutput("reset in_ready",  64'(aInReady),  64'd1);
    checkOutput("reset out_valid", 64'(aOutValid), 64'd0);
    checkOutput("reset out_sum",   64'(aOutSum),   64'd0);
    checkOutput("reset out_ovf",   64'(aOutOvf),   64'd0);
    rst = 1'b0;
    tick();
    checkOutput("post-reset in_ready", 64'(aInReady), 64'd1);

    // Basic frame of four products.
    aFrameLen = 8'd4;
    applyStimulus(22'd1);
    applyStimulus(22'd2);
    applyStimulus(22'd3);
    checkOutput("basic no early valid", 64'(aOutValid), 64'd0);
    applyStimulus(22'd4);
    checkOutput("basic out_valid", 64'(aOutValid), 64'd1);
    checkOutput("basic out_sum",   64'(aOutSum),   64'd10);
    checkOutput("basic out_ovf",   64'(aOutOvf),   64'd0);
    checkOutput("basic in_ready low in OUT", 64'(aInReady), 64'd0);
    tick();
    checkOutput("basic out_valid drop", 64'(aOutValid), 64'd0);
    checkOutput("basic in_ready back",  64'(aInReady),  64'd1);

    // Backpressure with gaps between products.
    aFrameLen = 8'd3;
    aOutReady = 1'b0;
    applyStimulus(22'd4190209);
    tick();
    applyStimulus(22'd4190209);
    tick();
    checkOutput("gap no early valid", 64'(aOutValid), 64'd0);
    applyStimulus(22'd4190209);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp out_valid held", 64'(aOutValid), 64'd1);
      checkOutput("bp out_sum held",   64'(aOutSum),   64'd12570627);
      checkOutput("bp in_ready low",   64'(aInReady),  64'd0);
      tick();
    end
    checkOutput("bp out_ovf", 64'(aOutOvf), 64'd0);
    aOutReady = 1'b1;
    tick();
    checkOutput("bp release out_valid", 64'(aOutValid), 64'd0);
    checkOutput("bp release in_ready",  64'(aInReady),  64'd1);

    // Zero length behaves as a one-product frame.
    aFrameLen = 8'd0;
    applyStimulus(22'd4190209);
    checkOutput("len0 out_valid", 64'(aOutValid), 64'd1);
    checkOutput("len0 out_sum",   64'(aOutSum),   64'd4190209);
    tick();

    // Length latched on the first product; later changes ignored.
    aFrameLen = 8'd2;
    applyStimulus(22'd11);
    aFrameLen = 8'd7;
    applyStimulus(22'd22);
    checkOutput("latch out_valid", 64'(aOutValid), 64'd1);
    checkOutput("latch out_sum",   64'(aOutSum),   64'd33);
    tick();
    checkOutput("latch back to ACC", 64'(aInReady), 64'd1);

    // Reset mid-frame discards the partial sum.
    aFrameLen = 8'd4;
    applyStimulus(22'd100);
    applyStimulus(22'd200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst in_ready",  64'(aInReady),  64'd1);
    checkOutput("midrst out_valid", 64'(aOutValid), 64'd0);
    aFrameLen = 8'd2;
    applyStimulus(22'd7);
    checkOutput("midrst no valid after 1", 64'(aOutValid), 64'd0);
    applyStimulus(22'd8);
    checkOutput("midrst out_valid", 64'(aOutValid), 64'd1);
    checkOutput("midrst out_sum",   64'(aOutSum),   64'd15);

    // Reset while holding a result in OUT.
    aOutReady = 1'b0;
    tick();
    checkOutput("outrst held valid", 64'(aOutValid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("outrst out_valid", 64'(aOutValid), 64'd0);
    checkOutput("outrst in_ready",  64'(aInReady),  64'd1);
    checkOutput("outrst out_sum",   64'(aOutSum),   64'd0);
    aOutReady = 1'b1;

    // Overflow on the 23-bit accumulator.
    bFrameLen = 8'd3;
    applyStimulusB(22'h3FFFFF);
    applyStimulusB(22'h3FFFFF);
    applyStimulusB(22'h3FFFFF);
    checkOutput("ovf out_valid", 64'(bOutValid), 64'd1);
`ifdef ACC_SATURATE_EN
    checkOutput("ovf out_sum", 64'(bOutSum), 64'h7FFFFF);
`else
    checkOutput("ovf out_sum", 64'(bOutSum), 64'h3FFFFD);
`endif
    checkOutput("ovf out_ovf", 64'(bOutOvf), 64'd1);
    tick();

    // Following frame starts with a clean accumulator and flag.
    bFrameLen = 8'd1;
    applyStimulusB(22'd5);
    checkOutput("postovf out_valid", 64'(bOutValid), 64'd1);
    checkOutput("postovf out_sum",   64'(bOutSum),   64'd5);
    checkOutput("postovf out_ovf",   64'(bOutOvf),   64'd0);
    tick();
    checkOutput("postovf in_ready", 64'(bInReady), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule : tb_mult_accum_stage
